// File: rtl/resp_tx16.sv
// resp_tx16: serialises a 16-bit response word onto a UART line as two
// 8N1 frames, high byte first, with an internal baud generator.
module resp_tx16 #(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_resp,
  input  logic [15:0] resp,
  output logic        TX,
  output logic        busy,
  output logic        resp_snt
);

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned FRAME_W = BYTE_W + 2;
  localparam int unsigned BAUD_W  = 16;
  localparam int unsigned BIT_W   = 4;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} state_e;

  state_e             state_q;
  logic [WORD_W-1:0]  hold_q;
  logic [FRAME_W-1:0] shift_q;
  logic [BAUD_W-1:0]  baud_q;
  logic [BIT_W-1:0]   bit_q;
  logic               done_q;
  logic               tx_q;
  logic               busy_q;
  logic               snt_q;
  logic               bit_end_c;
  logic               frame_end_c;

  assign bit_end_c   = (baud_q == BAUD_LAST);
  assign frame_end_c = bit_end_c && (bit_q == BIT_LAST);

  // Stop bit in the MSB, start bit in the LSB; the shifter drains LSB first.
  function automatic logic [FRAME_W-1:0] frame(input logic [BYTE_W-1:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      shift_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      snt_q   <= 1'b0;
    end else begin
      // Output stage: one register behind the sequencer, so nothing from the inputs reaches TX directly.
      tx_q   <= (state_q == IDLE) ? 1'b1 : shift_q[0];
      busy_q <= (state_q != IDLE);
      snt_q  <= done_q;

      case (state_q)
        IDLE: begin
          if (snd_resp && !busy_q) begin
            hold_q  <= resp;
            shift_q <= frame(resp[15:8]);
            baud_q  <= '0;
            bit_q   <= '0;
            done_q  <= 1'b0;
            state_q <= SEND_HI;
          end
        end
        SEND_HI, SEND_LO: begin
          if (bit_end_c) begin
            baud_q <= '0;
            if (frame_end_c) begin
              bit_q <= '0;
              if (state_q == SEND_HI) begin
                shift_q <= frame(hold_q[7:0]);
                // Rotate so hold_q[15:8] always names the byte now on the wire.
                hold_q  <= {hold_q[7:0], hold_q[15:8]};
                state_q <= SEND_LO;
              end else begin
                shift_q <= '1;
                done_q  <= 1'b1;
                state_q <= IDLE;
              end
            end else begin
              bit_q   <= bit_q + BIT_W'(1);
              shift_q <= {1'b1, shift_q[FRAME_W-1:1]};
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign TX       = tx_q;
  assign busy     = busy_q;
  assign resp_snt = snt_q;

endmodule

// File: tb/tb_resp_tx16.sv
// tb_resp_tx16: directed stimulus for resp_tx16; a UART receive monitor
// pops expected bytes from a scoreboard queue as each frame arrives.
module tb_resp_tx16;

  localparam int unsigned BD      = 16;
  localparam int unsigned XFER_LAT = 20 * BD + 1;

  logic        clk;
  logic        rst_n;
  logic        snd_resp;
  logic [15:0] resp;
  logic        TX;
  logic        busy;
  logic        resp_snt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc   = 0;

  logic [7:0] exp_q[$];

  resp_tx16 #(.BAUD_DIV(BD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .snd_resp (snd_resp),
    .resp     (resp),
    .TX       (TX),
    .busy     (busy),
    .resp_snt (resp_snt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART receive monitor: mid-bit sampling on the falling edge.
  int         rx_cnt = 0;
  int         rx_idx = 0;
  bit         rx_act = 0;
  logic [7:0] rx_byte;
  logic [7:0] rx_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_act = 0;
    end else if (!rx_act) begin
      if (TX === 1'b0) begin
        rx_act = 1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt = rx_cnt + 1;
      if ((rx_cnt % BD) == BD / 2) begin
        rx_idx = rx_cnt / BD;
        if (rx_idx == 0) begin
          chk("rx_start_bit", 32'(TX), 32'd0);
        end else if (rx_idx <= 8) begin
          rx_byte[rx_idx-1] = TX;
        end else begin
          chk("rx_stop_bit", 32'(TX), 32'd1);
          if (exp_q.size() == 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL rx_unexpected: got byte %0h want none", rx_byte);
          end else begin
            rx_exp = exp_q.pop_front();
            chk("rx_byte", 32'(rx_byte), 32'(rx_exp));
          end
          rx_act = 0;
        end
      end
    end
  end

  task automatic pulse(input logic [15:0] w);
    resp     = w;
    snd_resp = 1'b1;
    @(posedge clk);
    #1;
    snd_resp = 1'b0;
    resp     = ~w;
    acc      = cyc;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (resp_snt === 1'b1) break;
    end
    chk(name, 32'(cyc - acc), 32'(XFER_LAT));
    chk({name, "_idle"}, {30'd0, TX, busy}, 32'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    snd_resp = 1'b0;
    resp     = 16'h0000;

    // Reset values and stability under reset.
    @(posedge clk);
    #1;
    chk("rst_vals", {29'd0, TX, busy, resp_snt}, 32'b100);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold", {29'd0, TX, busy, resp_snt}, 32'b100);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic transfer.
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hC3);
    pulse(16'hA5C3);
    chk("accept_edge", {30'd0, TX, busy}, 32'b10);
    @(posedge clk);
    #1;
    chk("start_lat", {29'd0, TX, busy, resp_snt}, 32'b010);
    wait_done("basic_lat");

    // Loopback words; resp_snt drops one cycle after each new request.
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    pulse(16'h1234);
    chk("snt_hold_1234", 32'(resp_snt), 32'd1);
    @(posedge clk);
    #1;
    chk("snt_drop_1234", 32'(resp_snt), 32'd0);
    wait_done("lat_1234");

    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    pulse(16'hFFFF);
    chk("snt_hold_ffff", 32'(resp_snt), 32'd1);
    @(posedge clk);
    #1;
    chk("snt_drop_ffff", 32'(resp_snt), 32'd0);
    wait_done("lat_ffff");

    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    pulse(16'h0000);
    chk("snt_hold_0000", 32'(resp_snt), 32'd1);
    @(posedge clk);
    #1;
    chk("snt_drop_0000", 32'(resp_snt), 32'd0);
    wait_done("lat_0000");

    // Request while busy is ignored.
    exp_q.push_back(8'hBE);
    exp_q.push_back(8'hEF);
    pulse(16'hBEEF);
    repeat (49) @(posedge clk);
    #1;
    resp     = 16'h0000;
    snd_resp = 1'b1;
    @(posedge clk);
    #1;
    snd_resp = 1'b0;
    chk("ignore_busy", 32'(busy), 32'd1);
    wait_done("ignore_lat");

    // Reset in the middle of the low byte.
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h57);
    pulse(16'h1357);
    repeat (250) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_vals", {29'd0, TX, busy, resp_snt}, 32'b100);
    chk("midrst_pending", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_quiet", {29'd0, TX, busy, resp_snt}, 32'b100);
    end
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    pulse(16'h00FF);
    wait_done("after_rst_lat");

    // Back-to-back: request on the first cycle busy is low.
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hA5);
    pulse(16'h5AA5);
    wait_done("b2b_first_lat");
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    resp     = 16'h3CC3;
    snd_resp = 1'b1;
    @(posedge clk);
    #1;
    snd_resp = 1'b0;
    acc      = cyc;
    chk("b2b_idle", {30'd0, TX, busy}, 32'b10);
    @(posedge clk);
    #1;
    chk("b2b_start", {29'd0, TX, busy, resp_snt}, 32'b010);
    wait_done("b2b_second_lat");

    repeat (40) @(posedge clk);
    #1;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
